// File: rtl/comparator_arbiter_if.sv
// comparator_arbiter_if: request/response bundle between NUM_REQ comparator
// clients (master side) and the shared comparator_arbiter (slave side).
// Operands are packed per requester: requester i owns
// req_a/req_b[i*WIDTH +: WIDTH] and req_op[i*3 +: 3].
interface comparator_arbiter_if #(
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  // Request channel, one valid/ready pair per requester
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ*3-1:0]     req_op;

  // Response channel, tagged with the owning requester
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic                     rsp_result;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result
  );
endinterface

// File: rtl/comparator_arbiter.sv
// comparator_arbiter: arbitrates NUM_REQ requesters onto one shared
// magnitude comparator and returns a tagged 1-bit result.
// One transaction in flight at a time: IDLE (grant) -> EXEC (compare)
// -> RESP (hold until consumed).
// Build macro: CMP_ARB_FIXED_PRIORITY_EN -- when defined, the lowest
// valid index always wins and the round-robin pointer is removed;
// when undefined (default) arbitration is round-robin.
module comparator_arbiter #(
  parameter int WIDTH          = 16,
  parameter int NUM_REQ        = 4,
  parameter int SIGNED_COMPARE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  comparator_arbiter_if.slave  bus,
  output logic                 busy
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Op encodings; 110/111 are reserved and evaluate to 0
  typedef enum logic [2:0] {
    OP_EQ = 3'b000,
    OP_NE = 3'b001,
    OP_LT = 3'b010,
    OP_LE = 3'b011,
    OP_GT = 3'b100,
    OP_GE = 3'b101
  } cmp_op_t;

  state_t              state_q;
  logic                rsp_valid_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic                rsp_result_q;
  logic                busy_q;

  // Latched transaction
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic [2:0]          op_q;
  logic [ID_W-1:0]     id_q;

  // Arbitration results
  logic                grant_found;
  logic [ID_W-1:0]     grant_id;
  logic [NUM_REQ-1:0]  grant_onehot;
  logic                accept;

  // Winner's operands
  logic [WIDTH-1:0]    sel_a;
  logic [WIDTH-1:0]    sel_b;
  logic [2:0]          sel_op;

  // Comparator
  logic [WIDTH-1:0]    a_cmp;
  logic [WIDTH-1:0]    b_cmp;
  logic                cmp_eq;
  logic                cmp_lt;
  logic                cmp_result;

`ifndef CMP_ARB_FIXED_PRIORITY_EN
  // Round-robin pointer: first index searched on the next arbitration
  logic [ID_W-1:0]     ptr_q;
  logic [ID_W:0]       cand_sum;
`endif
  logic [ID_W-1:0]     cand;

  // Pick the winner: first valid requester searched from the pointer (or from 0)
  always_comb begin
    // NOTE: every variable gets a default before any conditional write so
    // no path leaves it unassigned, which would otherwise infer a latch.
    grant_found  = 1'b0;
    grant_id     = '0;
    grant_onehot = '0;
    cand         = '0;
`ifndef CMP_ARB_FIXED_PRIORITY_EN
    cand_sum     = '0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef CMP_ARB_FIXED_PRIORITY_EN
      cand = ID_W'(i);
`else
      cand_sum = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (cand_sum >= (ID_W+1)'(NUM_REQ)) begin
        cand_sum = cand_sum - (ID_W+1)'(NUM_REQ);
      end
      cand = cand_sum[ID_W-1:0];
`endif
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found        = 1'b1;
        grant_id           = cand;
        grant_onehot       = '0;
        grant_onehot[cand] = 1'b1;
      end
    end
  end

  // Route the winner's operand slices toward the capture registers
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_a  = bus.req_a[i*WIDTH +: WIDTH];
        sel_b  = bus.req_b[i*WIDTH +: WIDTH];
        sel_op = bus.req_op[i*3 +: 3];
      end
    end
  end

  // Grant only while idle and out of reset; at most one ready bit is ever high
  assign accept        = (state_q == IDLE) && grant_found && !rst;
  assign bus.req_ready = accept ? grant_onehot : '0;

  // Capture the granted transaction
  // NOTE: the operand/op/id capture registers carry no reset: they are only
  // read after an accept has loaded them, and rsp_id/rsp_result (which are
  // reset) are what the outside world sees.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= sel_a;
      b_q  <= sel_b;
      op_q <= sel_op;
      id_q <= grant_id;
    end
  end

  // Shared comparator: signed compare is done unsigned with sign bits inverted
  always_comb begin
    a_cmp = a_q;
    b_cmp = b_q;
    if (SIGNED_COMPARE != 0) begin
      a_cmp[WIDTH-1] = ~a_q[WIDTH-1];
      b_cmp[WIDTH-1] = ~b_q[WIDTH-1];
    end
    cmp_eq = (a_q == b_q);
    cmp_lt = (a_cmp < b_cmp);
    case (op_q)
      OP_EQ:   cmp_result = cmp_eq;
      OP_NE:   cmp_result = !cmp_eq;
      OP_LT:   cmp_result = cmp_lt;
      OP_LE:   cmp_result = cmp_lt || cmp_eq;
      OP_GT:   cmp_result = !(cmp_lt || cmp_eq);
      OP_GE:   cmp_result = !cmp_lt;
      default: cmp_result = 1'b0;
    endcase
  end

  // Control FSM with registered response, busy and pointer
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= IDLE;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= 1'b0;
      busy_q       <= 1'b0;
`ifndef CMP_ARB_FIXED_PRIORITY_EN
      ptr_q        <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= EXEC;
            busy_q  <= 1'b1;
`ifndef CMP_ARB_FIXED_PRIORITY_EN
            ptr_q   <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
`endif
          end
        end
        EXEC: begin
          state_q      <= RESP;
          rsp_valid_q  <= 1'b1;
          rsp_id_q     <= id_q;
          rsp_result_q <= cmp_result;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_comparator_arbiter.sv
// tb_comparator_arbiter: directed scoreboard bench. Two instances run in
// lockstep on identical stimulus, one unsigned and one signed, so each
// vector carries both hand-computed results. Expected responses are queued
// at issue time; a negedge monitor pops and compares on every handshake.
`timescale 1ns/1ps
module tb_comparator_arbiter;
  localparam int WIDTH   = 16;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  localparam logic [2:0] EQ = 3'b000, NE = 3'b001, LT = 3'b010,
                         LE = 3'b011, GT = 3'b100, GE = 3'b101;

  logic clk = 1'b0;
  logic rst;
  logic busy_u, busy_s;

  always #5 clk = ~clk;

  comparator_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) if_u ();
  comparator_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) if_s ();

  assign if_s.req_valid = if_u.req_valid;
  assign if_s.req_a     = if_u.req_a;
  assign if_s.req_b     = if_u.req_b;
  assign if_s.req_op    = if_u.req_op;
  assign if_s.rsp_ready = if_u.rsp_ready;

  comparator_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .SIGNED_COMPARE(0)) dut_u (
    .clk(clk), .rst(rst), .bus(if_u), .busy(busy_u));
  comparator_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .SIGNED_COMPARE(1)) dut_s (
    .clk(clk), .rst(rst), .bus(if_s), .busy(busy_s));

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            res_u;
    logic            res_s;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   accept_count = 0;
  int   rsp_count    = 0;
  int   last_accept_edge = 0;
  int   last_rsp_edge    = 0;
  logic [NUM_REQ-1:0] last_accept_ready = '0;
  int   accept_edges[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: grant legality, accept bookkeeping and scoreboard compare
  always @(negedge clk) begin
    if (!rst) begin
      check("req_ready_onehot0", 32'($onehot0(if_u.req_ready)), 32'd1);
      if (|(if_u.req_valid & if_u.req_ready)) begin
        accept_count++;
        last_accept_edge  = cyc + 1;
        last_accept_ready = if_u.req_ready;
        accept_edges.push_back(cyc + 1);
      end
      if (if_u.rsp_valid && if_u.rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp: got id=%0d result=%0d, expected no response",
                   if_u.rsp_id, if_u.rsp_result);
        end else begin
          e = exp_q.pop_front();
          check("rsp_id_u",     32'(if_u.rsp_id),     32'(e.id));
          check("rsp_result_u", 32'(if_u.rsp_result), 32'(e.res_u));
          check("rsp_valid_s",  32'(if_s.rsp_valid),  32'd1);
          check("rsp_id_s",     32'(if_s.rsp_id),     32'(e.id));
          check("rsp_result_s", 32'(if_s.rsp_result), 32'(e.res_s));
        end
        rsp_count++;
        last_rsp_edge = cyc + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] op);
    if_u.req_a[i*WIDTH +: WIDTH] = a;
    if_u.req_b[i*WIDTH +: WIDTH] = b;
    if_u.req_op[i*3 +: 3]        = op;
    if_u.req_valid[i]            = 1'b1;
  endtask

  task automatic push_exp(input int id, input logic ru, input logic rs);
    exp_t x;
    x.id    = ID_W'(id);
    x.res_u = ru;
    x.res_s = rs;
    exp_q.push_back(x);
  endtask

  task automatic wait_accepts(input int target, input string name);
    int n = 0;
    while (accept_count < target && n < 50) begin
      tick();
      n++;
    end
    check(name, 32'(accept_count), 32'(target));
  endtask

  task automatic wait_rsps(input int target, input string name);
    int n = 0;
    while (rsp_count < target && n < 100) begin
      tick();
      n++;
    end
    check(name, 32'(rsp_count), 32'(target));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"},  32'(if_u.req_ready),  32'd0);
    check({tag, "_rsp_valid"},  32'(if_u.rsp_valid),  32'd0);
    check({tag, "_rsp_id"},     32'(if_u.rsp_id),     32'd0);
    check({tag, "_rsp_result"}, 32'(if_u.rsp_result), 32'd0);
    check({tag, "_busy"},       32'(busy_u),          32'd0);
    check({tag, "_busy_s"},     32'(busy_s),          32'd0);
    check({tag, "_rsp_valid_s"},32'(if_s.rsp_valid),  32'd0);
  endtask

  // Stimulus
  initial begin
    int base_a, base_r;
    logic [7:0] sweep_exp;

    rst = 1'b1;
    if_u.req_valid = '0;
    if_u.req_a     = '0;
    if_u.req_b     = '0;
    if_u.req_op    = '0;
    if_u.rsp_ready = 1'b1;

    // Reset with random inputs: everything stays zero
    for (int k = 0; k < 5; k++) begin
      if_u.req_valid = NUM_REQ'($urandom);
      if_u.req_a     = (NUM_REQ*WIDTH)'({$urandom, $urandom});
      if_u.req_b     = (NUM_REQ*WIDTH)'({$urandom, $urandom});
      if_u.req_op    = (NUM_REQ*3)'($urandom);
      if_u.rsp_ready = 1'($urandom);
      @(negedge clk);
      check_idle_outputs("reset");
    end
    if_u.req_valid = '0;
    if_u.rsp_ready = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Fairness: all valid, rsp_ready high; back-to-back every 3 cycles
    accept_edges.delete();
`ifdef CMP_ARB_FIXED_PRIORITY_EN
    for (int k = 0; k < 5; k++) push_exp(0, 1'b1, 1'b1);
`else
    push_exp(0, 1'b1, 1'b1);
    push_exp(1, 1'b1, 1'b0);
    push_exp(2, 1'b0, 1'b0);
    push_exp(3, 1'b0, 1'b1);
    push_exp(0, 1'b1, 1'b1);
`endif
    base_r = rsp_count;
    set_req(0, 16'h0001, 16'h0002, LT);
    set_req(1, 16'h8000, 16'h0001, GT);
    set_req(2, 16'hFFFF, 16'hFFFF, NE);
    set_req(3, 16'h7FFF, 16'h8000, GE);
    wait_rsps(base_r + 5, "fair_rsp_count");
    if_u.req_valid = '0;
    check("fair_accept_count", 32'(accept_edges.size()), 32'd5);
    for (int k = 1; k < accept_edges.size(); k++) begin
      check("fair_issue_interval", 32'(accept_edges[k] - accept_edges[k-1]), 32'd3);
    end

    // Single request from requester 2: 5 < 0xFFFF unsigned, 5 < -1 false signed
    push_exp(2, 1'b1, 1'b0);
    base_a = accept_count;
    base_r = rsp_count;
    set_req(2, 16'h0005, 16'hFFFF, LT);
    wait_accepts(base_a + 1, "single_accept");
    if_u.req_valid = '0;
    check("single_grant", 32'(last_accept_ready), 32'b0100);
    wait_rsps(base_r + 1, "single_rsp");
    check("single_latency", 32'(last_rsp_edge - last_accept_edge), 32'd2);

    // Op sweep with a == b
    sweep_exp = 8'b0010_1001; // bit k = expected result of op k
    for (int op = 0; op < 8; op++) begin
      push_exp(1, sweep_exp[op], sweep_exp[op]);
      base_a = accept_count;
      base_r = rsp_count;
      set_req(1, 16'h1234, 16'h1234, 3'(op));
      wait_accepts(base_a + 1, "sweep_accept");
      if_u.req_valid = '0;
      wait_rsps(base_r + 1, "sweep_rsp");
    end

    // Backpressure: response held 10 cycles, no second accept
    if_u.rsp_ready = 1'b0;
    push_exp(3, 1'b1, 1'b0);
    base_a = accept_count;
    base_r = rsp_count;
    set_req(3, 16'hFFFF, 16'h0001, GT);
    wait_accepts(base_a + 1, "bp_accept");
    if_u.req_valid = '0;
    begin
      int n = 0;
      while (!if_u.rsp_valid && n < 20) begin
        tick();
        n++;
      end
    end
    push_exp(0, 1'b1, 1'b1);
    set_req(0, 16'h0003, 16'h0003, LE);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_rsp_valid",    32'(if_u.rsp_valid),  32'd1);
      check("bp_rsp_id",       32'(if_u.rsp_id),     32'd3);
      check("bp_rsp_result_u", 32'(if_u.rsp_result), 32'd1);
      check("bp_rsp_result_s", 32'(if_s.rsp_result), 32'd0);
      check("bp_req_ready",    32'(if_u.req_ready),  32'd0);
      check("bp_busy",         32'(busy_u),          32'd1);
      check("bp_no_accept",    32'(accept_count),    32'(base_a + 1));
    end
    @(posedge clk);
    #1;
    if_u.rsp_ready = 1'b1;
    wait_rsps(base_r + 1, "bp_rsp");
    wait_accepts(base_a + 2, "bp_next_accept");
    if_u.req_valid = '0;
    check("bp_next_grant", 32'(last_accept_ready), 32'b0001);
    wait_rsps(base_r + 2, "bp_next_rsp");

    // Reset during EXEC: in-flight response dropped, pointer back to 0
    base_a = accept_count;
    set_req(1, 16'h0000, 16'h0000, EQ);
    wait_accepts(base_a + 1, "rst_accept");
    if_u.req_valid = '0;
    check("rst_busy_before", 32'(busy_u), 32'd1);
    rst = 1'b1;
    #2;
    check_idle_outputs("midrst");
    tick();
    tick();
    rst = 1'b0;
    push_exp(0, 1'b1, 1'b1);
    base_a = accept_count;
    base_r = rsp_count;
    set_req(2, 16'h0000, 16'h0000, EQ);
    set_req(0, 16'h0009, 16'h0004, GT);
    wait_accepts(base_a + 1, "post_rst_accept");
    if_u.req_valid = '0;
    check("post_rst_grant", 32'(last_accept_ready), 32'b0001);
    wait_rsps(base_r + 1, "post_rst_rsp");

    repeat (5) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time guard
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
